// File: rtl/aster_pkg.sv
// Shared definitions for the asteroid motion engine: widths, entry layout,
// direction codes and FSM state encoding.
package aster_pkg;

    localparam int unsigned COORD_W = 4;
    localparam int unsigned DIR_W   = 2;
    localparam int unsigned ENTRY_W = 2 * COORD_W + DIR_W;

    // Entry layout, MSB first: x | y | dir
    localparam int unsigned DIR_LSB = 0;
    localparam int unsigned DIR_MSB = DIR_LSB + DIR_W - 1;
    localparam int unsigned Y_LSB   = DIR_MSB + 1;
    localparam int unsigned Y_MSB   = Y_LSB + COORD_W - 1;
    localparam int unsigned X_LSB   = Y_MSB + 1;
    localparam int unsigned X_MSB   = X_LSB + COORD_W - 1;

    localparam logic [DIR_W-1:0] DIR_XMAIS  = 2'b00;
    localparam logic [DIR_W-1:0] DIR_XMENOS = 2'b01;
    localparam logic [DIR_W-1:0] DIR_YMAIS  = 2'b10;
    localparam logic [DIR_W-1:0] DIR_YMENOS = 2'b11;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        LEITURA = 2'd1,
        ESCRITA = 2'd2,
        FIM     = 2'd3
    } estado_t;

endpackage

// File: rtl/passo_aster.sv
// One-step move of a single asteroid entry (combinational).
// ATUALIZADOR_SATURA_EN: when defined, coordinates clamp at the grid edge and
// the direction is reversed so the asteroid bounces; otherwise coordinates
// wrap modulo 2**COORD_W and the direction is kept.
module passo_aster
    import aster_pkg::*;
(
    input  logic [ENTRY_W-1:0] entrada,
    output logic [ENTRY_W-1:0] saida
);

`ifdef ATUALIZADOR_SATURA_EN
    localparam logic [COORD_W-1:0] COORD_MAX = '1;
    localparam logic [COORD_W-1:0] COORD_MIN = '0;
`endif

    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [DIR_W-1:0]   dir;
    logic [COORD_W-1:0] x_n;
    logic [COORD_W-1:0] y_n;
    logic [DIR_W-1:0]   dir_n;

    assign x   = entrada[X_MSB:X_LSB];
    assign y   = entrada[Y_MSB:Y_LSB];
    assign dir = entrada[DIR_MSB:DIR_LSB];

    // Advance one cell along the direction field
    always_comb begin
        x_n   = x;
        y_n   = y;
        dir_n = dir;
        unique case (dir)
            DIR_XMAIS: begin
`ifdef ATUALIZADOR_SATURA_EN
                if (x == COORD_MAX) dir_n = DIR_XMENOS;
                else                x_n   = x + COORD_W'(1);
`else
                x_n = x + COORD_W'(1);
`endif
            end
            DIR_XMENOS: begin
`ifdef ATUALIZADOR_SATURA_EN
                if (x == COORD_MIN) dir_n = DIR_XMAIS;
                else                x_n   = x - COORD_W'(1);
`else
                x_n = x - COORD_W'(1);
`endif
            end
            DIR_YMAIS: begin
`ifdef ATUALIZADOR_SATURA_EN
                if (y == COORD_MAX) dir_n = DIR_YMENOS;
                else                y_n   = y + COORD_W'(1);
`else
                y_n = y + COORD_W'(1);
`endif
            end
            DIR_YMENOS: begin
`ifdef ATUALIZADOR_SATURA_EN
                if (y == COORD_MIN) dir_n = DIR_YMAIS;
                else                y_n   = y - COORD_W'(1);
`else
                y_n = y - COORD_W'(1);
`endif
            end
        endcase
    end

    assign saida = {x_n, y_n, dir_n};

endmodule

// File: rtl/atualizador_aster.sv
// Asteroid motion engine: on each start pulse it sweeps the active entries of
// the asteroid RAM (read, move, write back) and flags a landing on the ship.
// The RAM has one cycle of read latency, so each entry takes a LEITURA cycle
// (address presented) and an ESCRITA cycle (q valid, moved entry written).
// Optional macro ATUALIZADOR_SATURA_EN selects saturate-and-bounce edges.
module atualizador_aster #(
    parameter int unsigned N_ASTER = 16,
    parameter int unsigned COORD_W = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       iniciar,
    input  logic [$clog2(N_ASTER):0]   num_aster,
    input  logic [COORD_W-1:0]         nave_x,
    input  logic [COORD_W-1:0]         nave_y,
    input  logic [2*COORD_W+1:0]       mem_q,
    output logic                       mem_we,
    output logic [$clog2(N_ASTER)-1:0] mem_addr,
    output logic [2*COORD_W+1:0]       mem_data,
    output logic                       ocupado,
    output logic                       pronto,
    output logic                       colisao
);

    import aster_pkg::*;

    localparam int unsigned ADDR_W = $clog2(N_ASTER);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_ASTER);

    estado_t             estado_q, estado_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]    total_q, total_d;
    logic [COORD_W-1:0]  nave_x_q, nave_x_d;
    logic [COORD_W-1:0]  nave_y_q, nave_y_d;
    logic                colisao_q, colisao_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                ocupado_q, ocupado_d;
    logic                pronto_q, pronto_d;

    logic [CNT_W-1:0]    num_clamp;
    logic                ultimo;
    logic                acerto;
    logic [ENTRY_W-1:0]  movido;

    // Moved version of the entry currently on the RAM read port
    passo_aster u_passo (
        .entrada (mem_q),
        .saida   (movido)
    );

    // Clamp request, last-entry and ship-hit detection
    always_comb begin
        num_clamp = (num_aster > CNT_MAX) ? CNT_MAX : num_aster;
        ultimo    = (CNT_W'(idx_q) == (total_q - CNT_W'(1)));
        acerto    = (movido[X_MSB:X_LSB] == nave_x_q) &&
                    (movido[Y_MSB:Y_LSB] == nave_y_q);
    end

    // Next-state logic; registered outputs are derived from the next state so
    // address and write enable are already valid during the state they belong to
    always_comb begin
        estado_d   = estado_q;
        idx_d      = idx_q;
        total_d    = total_q;
        nave_x_d   = nave_x_q;
        nave_y_d   = nave_y_q;
        colisao_d  = colisao_q;

        case (estado_q)
            OCIOSO: begin
                if (iniciar) begin
                    nave_x_d  = nave_x;
                    nave_y_d  = nave_y;
                    total_d   = num_clamp;
                    colisao_d = 1'b0;
                    idx_d     = '0;
                    estado_d  = (num_clamp == '0) ? FIM : LEITURA;
                end
            end
            LEITURA: begin
                estado_d = ESCRITA;
            end
            ESCRITA: begin
                if (acerto) colisao_d = 1'b1;
                if (ultimo) begin
                    estado_d = FIM;
                end else begin
                    idx_d    = idx_q + ADDR_W'(1);
                    estado_d = LEITURA;
                end
            end
            FIM: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase

        mem_we_d   = (estado_d == ESCRITA);
        ocupado_d  = (estado_d == LEITURA) || (estado_d == ESCRITA);
        pronto_d   = (estado_d == FIM);
        mem_addr_d = ocupado_d ? idx_d : mem_addr_q;
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_q   <= OCIOSO;
            idx_q      <= '0;
            total_q    <= '0;
            nave_x_q   <= '0;
            nave_y_q   <= '0;
            colisao_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            idx_q      <= idx_d;
            total_q    <= total_d;
            nave_x_q   <= nave_x_d;
            nave_y_q   <= nave_y_d;
            colisao_q  <= colisao_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            ocupado_q  <= ocupado_d;
            pronto_q   <= pronto_d;
        end
    end

    // Write data depends on q, which only arrives during ESCRITA
    assign mem_data = (estado_q == ESCRITA) ? movido : '0;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign ocupado  = ocupado_q;
    assign pronto   = pronto_q;
    assign colisao  = colisao_q;

endmodule
